load_rs_scheduler: RTL and testbench
====================================

LOAD_RS_SCHEDULER -- requirements
Module: load_rs_scheduler

Interface
REQ-001 Parameter NUM_ENTRIES, default 4, number of load reservation slots (power of two, 2..16).
REQ-002 Parameter NUM_PHYS_REGS, default 64, physical register count; PR_W = log2(NUM_PHYS_REGS).
REQ-003 Parameter ROB_W, default 4, ROB index width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-006 flush  input  1  mispredict flush; discard all entries.
REQ-007 disp_valid  input  1  dispatch presents a load.
REQ-008 disp_ready  output  1  a slot is free; dispatch accepted when disp_valid & disp_ready.
REQ-009 disp_ps1 / disp_pd  input  PR_W each  base-address source / destination physical register.
REQ-010 disp_rob  input  ROB_W  ROB index of the load.
REQ-011 disp_dep_valid / disp_dep_rob  input  1 / ROB_W  older-store dependency present / its ROB index.
REQ-012 disp_imm  input  32  address offset.
REQ-013 valid_reg  input  NUM_PHYS_REGS  per-register ready bits.
REQ-014 cdb_valid / cdb_rob  input  1 / ROB_W  store-completion broadcast.
REQ-015 issue_valid  output  1  a READY entry is offered to the load unit.
REQ-016 issue_ready  input  1  load unit accepts; handshake = issue_valid & issue_ready.
REQ-017 issue_ps1, issue_pd, issue_rob, issue_imm  output  PR_W, PR_W, ROB_W, 32  fields of the offered entry.
REQ-018 occupancy  output  log2(NUM_ENTRIES)+1  count of non-EMPTY slots; full / empty  output  1 each.

Function
REQ-019 Each slot SHALL hold a state in {EMPTY, WAIT_FOR_STORE, WAIT_FOR_REG, READY} plus the dispatched fields.
REQ-020 disp_ready SHALL equal ~full, computed from registered state only; a slot freed by issue in cycle N is reusable from cycle N+1.
REQ-021 An accepted dispatch SHALL write the lowest-index EMPTY slot at the next edge.
REQ-022 Initial state: WAIT_FOR_STORE if disp_dep_valid and not (cdb_valid & cdb_rob==disp_dep_rob) that cycle; otherwise WAIT_FOR_REG.
REQ-023 WAIT_FOR_STORE -> WAIT_FOR_REG at the edge where cdb_valid & cdb_rob==stored dep_rob; else hold.
REQ-024 WAIT_FOR_REG -> READY at the edge where valid_reg[ps1]==1; else hold.
REQ-025 READY holds until issued; an issued slot goes EMPTY at the next edge.
REQ-026 Age order SHALL be tracked (age matrix or equivalent): a newly allocated slot is younger than every occupied slot.
REQ-027 issue_valid SHALL be 1 iff any slot is READY and flush=0; the offered slot is the oldest READY slot; issue_* are combinational from registered state, zero when issue_valid=0.
REQ-028 Offered entry SHALL stay stable while issue_valid & ~issue_ready, unless an older slot becomes READY (re-selection permitted).
REQ-029 Minimum latency: dispatch with no dependency and ps1 already valid -> issue_valid two cycles after acceptance (WAIT_FOR_REG, then READY).
REQ-030 occupancy/full/empty SHALL reflect registered state; full = (occupancy==NUM_ENTRIES).
REQ-031 flush=1: all slots EMPTY at next edge; same-cycle dispatch and issue handshake ignored; age state cleared.
REQ-032 Simultaneous dispatch, CDB match and issue in one cycle SHALL all take effect independently on distinct slots.

Reset
REQ-033 rst=0 SHALL immediately force all slots EMPTY, clear age state; outputs: disp_ready=1, issue_valid=0, issue_*=0, occupancy=0, full=0, empty=1.
REQ-034 Reset mid-operation SHALL discard all in-flight entries without issuing any; normal operation resumes the first edge after rst=1.

Verification
REQ-035 Reset, dispatch ps1=5 (valid_reg[5]=1), rob=3, no dep -> issue_valid=1 two cycles later, issue_rob=3; with issue_ready=1 -> empty=1 next cycle.
REQ-036 Dispatch dep_rob=7, valid_reg[ps1]=1; cdb_rob=7 after 4 cycles -> WAIT_FOR_REG next edge, issue_valid one cycle later; cdb_rob=6 -> no change.
REQ-037 Fill 4 slots (rob 1..4) with ps1 invalid -> full=1, disp_ready=0; set all ps1 valid -> issues in order rob 1,2,3,4 with issue_ready held 1.
REQ-038 Full RS, issue in cycle N with disp_valid=1 -> dispatch refused in N, accepted in N+1 into the freed slot.
REQ-039 3 entries occupied, flush=1 one cycle with disp_valid=1 and issue_ready=1 -> occupancy=0, no issue handshake, no allocation.
REQ-040 Assert rst=0 asynchronously between edges with 2 READY entries -> issue_valid=0 and empty=1 before the next edge.

Source files
------------

// File: rtl/load_rs_scheduler.sv
// load_rs_scheduler: load reservation station; tracks store/register dependencies
// and offers the oldest ready load to the load unit.
module load_rs_scheduler #(
    parameter int NUM_ENTRIES   = 4,
    parameter int NUM_PHYS_REGS = 64,
    parameter int ROB_W         = 4,
    localparam int PR_W = $clog2(NUM_PHYS_REGS),
    localparam int IW   = $clog2(NUM_ENTRIES),
    localparam int OW   = IW + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [PR_W-1:0]          disp_ps1,
    input  logic [PR_W-1:0]          disp_pd,
    input  logic [ROB_W-1:0]         disp_rob,
    input  logic                     disp_dep_valid,
    input  logic [ROB_W-1:0]         disp_dep_rob,
    input  logic [31:0]              disp_imm,
    input  logic [NUM_PHYS_REGS-1:0] valid_reg,
    input  logic                     cdb_valid,
    input  logic [ROB_W-1:0]         cdb_rob,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [PR_W-1:0]          issue_ps1,
    output logic [PR_W-1:0]          issue_pd,
    output logic [ROB_W-1:0]         issue_rob,
    output logic [31:0]              issue_imm,
    output logic [OW-1:0]            occupancy,
    output logic                     full,
    output logic                     empty
);
    typedef enum logic [1:0] {EMPTY, WAIT_STORE, WAIT_REG, READY} slot_state_t;

    slot_state_t             state_q [NUM_ENTRIES];
    slot_state_t             state_d [NUM_ENTRIES];
    logic [PR_W-1:0]         ps1_q   [NUM_ENTRIES];
    logic [PR_W-1:0]         pd_q    [NUM_ENTRIES];
    logic [ROB_W-1:0]        rob_q   [NUM_ENTRIES];
    logic [ROB_W-1:0]        dep_q   [NUM_ENTRIES];
    logic [31:0]             imm_q   [NUM_ENTRIES];
    // older_q[i][j]: slot i was allocated before slot j
    logic [NUM_ENTRIES-1:0]  older_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]  busy, rdy, sel_oh;
    logic [IW-1:0]           alloc_idx, sel_idx;
    logic                    disp_fire, issue_fire, disp_hit;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_flags
        assign busy[g] = state_q[g] != EMPTY;
        assign rdy[g]  = state_q[g] == READY;
    end

    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (!busy[i]) alloc_idx = IW'(i);
    end

    // A ready slot wins only if no other ready slot is older than it
    always_comb begin
        sel_oh  = '0;
        sel_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            sel_oh[i] = rdy[i];
            for (int j = 0; j < NUM_ENTRIES; j++)
                if (rdy[j] && older_q[j][i]) sel_oh[i] = 1'b0;
            if (sel_oh[i]) sel_idx = IW'(i);
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            occupancy = occupancy + OW'(busy[i]);
    end

    assign full        = occupancy == OW'(NUM_ENTRIES);
    assign empty       = occupancy == '0;
    assign disp_ready  = ~full;
    assign disp_fire   = disp_valid & ~full & ~flush;
    assign issue_valid = (|rdy) & ~flush;
    assign issue_fire  = issue_valid & issue_ready;
    assign disp_hit    = cdb_valid && cdb_rob == disp_dep_rob;
    assign issue_ps1   = issue_valid ? ps1_q[sel_idx] : '0;
    assign issue_pd    = issue_valid ? pd_q[sel_idx]  : '0;
    assign issue_rob   = issue_valid ? rob_q[sel_idx] : '0;
    assign issue_imm   = issue_valid ? imm_q[sel_idx] : '0;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            if (flush)
                state_d[i] = EMPTY;
            else if (disp_fire && alloc_idx == IW'(i))
                state_d[i] = (disp_dep_valid && !disp_hit) ? WAIT_STORE : WAIT_REG;
            else if (issue_fire && sel_idx == IW'(i))
                state_d[i] = EMPTY;
            else if (state_q[i] == WAIT_STORE && cdb_valid && cdb_rob == dep_q[i])
                state_d[i] = WAIT_REG;
            else if (state_q[i] == WAIT_REG && valid_reg[ps1_q[i]])
                state_d[i] = READY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= EMPTY;
                ps1_q[i]   <= '0;
                pd_q[i]    <= '0;
                rob_q[i]   <= '0;
                dep_q[i]   <= '0;
                imm_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                if (flush)
                    older_q[i] <= '0;
                else if (disp_fire && alloc_idx == IW'(i))
                    older_q[i] <= '0;
                else if (disp_fire && busy[i])
                    older_q[i][alloc_idx] <= 1'b1;
            end
            if (disp_fire) begin
                ps1_q[alloc_idx] <= disp_ps1;
                pd_q[alloc_idx]  <= disp_pd;
                rob_q[alloc_idx] <= disp_rob;
                dep_q[alloc_idx] <= disp_dep_rob;
                imm_q[alloc_idx] <= disp_imm;
            end
        end
    end
endmodule

// File: tb/tb_load_rs_scheduler.sv
// tb_load_rs_scheduler: scenario tasks plus an issue scoreboard for load_rs_scheduler.
module tb_load_rs_scheduler;
    localparam int PW = 6;
    localparam int RW = 4;

    typedef struct packed {
        logic [RW-1:0] rob;
        logic [PW-1:0] pd;
        logic [PW-1:0] ps1;
        logic [31:0]   imm;
    } exp_t;

    logic          clk = 0, rst = 0, flush = 0;
    logic          disp_valid = 0, disp_ready, disp_dep_valid = 0;
    logic [PW-1:0] disp_ps1 = 0, disp_pd = 0;
    logic [RW-1:0] disp_rob = 0, disp_dep_rob = 0, cdb_rob = 0;
    logic [31:0]   disp_imm = 0;
    logic [63:0]   valid_reg = 0;
    logic          cdb_valid = 0, issue_valid, issue_ready = 0;
    logic [PW-1:0] issue_ps1, issue_pd;
    logic [RW-1:0] issue_rob;
    logic [31:0]   issue_imm;
    logic [2:0]    occupancy;
    logic          full, empty;

    int   compared = 0, mismatched = 0;
    exp_t sb[$];
    exp_t mon_e;

    load_rs_scheduler dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_ps1(disp_ps1), .disp_pd(disp_pd), .disp_rob(disp_rob),
        .disp_dep_valid(disp_dep_valid), .disp_dep_rob(disp_dep_rob), .disp_imm(disp_imm),
        .valid_reg(valid_reg), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_ps1(issue_ps1), .issue_pd(issue_pd), .issue_rob(issue_rob), .issue_imm(issue_imm),
        .occupancy(occupancy), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    // Every issue handshake must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (issue_valid && issue_ready) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL issue_unexpected: got rob=%0d, required no issue", issue_rob);
            end else begin
                mon_e = sb.pop_front();
                if ({issue_rob, issue_pd, issue_ps1, issue_imm} !== mon_e) begin
                    mismatched++;
                    $display("FAIL issue_entry: got rob=%0d pd=%0d ps1=%0d imm=%h, required rob=%0d pd=%0d ps1=%0d imm=%h",
                             issue_rob, issue_pd, issue_ps1, issue_imm, mon_e.rob, mon_e.pd, mon_e.ps1, mon_e.imm);
                end
            end
        end
        if (!issue_valid) begin
            compared++;
            if ({issue_rob, issue_pd, issue_ps1, issue_imm} !== '0) begin
                mismatched++;
                $display("FAIL issue_zero: got rob=%0d pd=%0d ps1=%0d imm=%h, required all zero",
                         issue_rob, issue_pd, issue_ps1, issue_imm);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input logic [PW-1:0] ps1, input logic [PW-1:0] pd, input logic [RW-1:0] rob,
                              input logic dv, input logic [RW-1:0] dr, input logic [31:0] imm);
        disp_valid = 1; disp_ps1 = ps1; disp_pd = pd; disp_rob = rob;
        disp_dep_valid = dv; disp_dep_rob = dr; disp_imm = imm;
    endtask

    task automatic idle_disp();
        disp_valid = 0;
        disp_dep_valid = 0;
    endtask

    task automatic drain();
        issue_ready = 1;
        for (int k = 0; k < 40 && sb.size() != 0; k++) cyc();
        issue_ready = 0;
    endtask

    task automatic test_reset();
        rst = 0; valid_reg = '1;
        drive_disp(6'd1, 6'd1, 4'd1, 1'b0, 4'd0, 32'h1);
        #1;
        compared++;
        if ({disp_ready, issue_valid, full, empty, occupancy} !== {1'b1, 1'b0, 1'b0, 1'b1, 3'd0}) begin
            mismatched++;
            $display("FAIL reset_outputs: got rdy=%b iv=%b full=%b empty=%b occ=%0d, required 1 0 0 1 0",
                     disp_ready, issue_valid, full, empty, occupancy);
        end
        @(posedge clk); @(negedge clk);
        compared++;
        if (occupancy !== 3'd0) begin
            mismatched++;
            $display("FAIL reset_hold: got occupancy=%0d, required 0", occupancy);
        end
        idle_disp(); valid_reg = '0;
        rst = 1;
        cyc();
    endtask

    task automatic test_basic();
        valid_reg = '0; valid_reg[5] = 1;
        drive_disp(6'd5, 6'd9, 4'd3, 1'b0, 4'd0, 32'h100);
        sb.push_back({4'd3, 6'd9, 6'd5, 32'h100});
        cyc(); idle_disp();
        @(negedge clk);
        compared++;
        if (issue_valid !== 1'b0 || occupancy !== 3'd1) begin
            mismatched++;
            $display("FAIL basic_latency1: got iv=%b occ=%0d, required iv=0 occ=1", issue_valid, occupancy);
        end
        cyc(); @(negedge clk);
        compared++;
        if (issue_valid !== 1'b1 || issue_rob !== 4'd3) begin
            mismatched++;
            $display("FAIL basic_issue: got iv=%b rob=%0d, required iv=1 rob=3", issue_valid, issue_rob);
        end
        cyc(); drain(); @(negedge clk);
        compared++;
        if (empty !== 1'b1 || sb.size() != 0) begin
            mismatched++;
            $display("FAIL basic_empty: got empty=%b pending=%0d, required empty=1 pending=0", empty, sb.size());
        end
        cyc();
    endtask

    task automatic test_dep_bypass();
        valid_reg = '0; valid_reg[5] = 1;
        drive_disp(6'd5, 6'd7, 4'd6, 1'b1, 4'd13, 32'h600);
        cdb_valid = 1; cdb_rob = 4'd13;
        sb.push_back({4'd6, 6'd7, 6'd5, 32'h600});
        cyc(); idle_disp(); cdb_valid = 0;
        @(negedge clk);
        compared++;
        if (issue_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL bypass_wait: got iv=%b, required 0", issue_valid);
        end
        cyc(); @(negedge clk);
        compared++;
        if (issue_valid !== 1'b1 || issue_rob !== 4'd6) begin
            mismatched++;
            $display("FAIL bypass_ready: got iv=%b rob=%0d, required iv=1 rob=6", issue_valid, issue_rob);
        end
        cyc(); drain(); @(negedge clk);
        compared++;
        if (empty !== 1'b1 || sb.size() != 0) begin
            mismatched++;
            $display("FAIL bypass_drain: got empty=%b pending=%0d, required 1 0", empty, sb.size());
        end
        cyc();
    endtask

    task automatic test_store_dep();
        logic stuck;
        valid_reg = '0; valid_reg[10] = 1;
        drive_disp(6'd10, 6'd11, 4'd5, 1'b1, 4'd7, 32'h200);
        sb.push_back({4'd5, 6'd11, 6'd10, 32'h200});
        cyc(); idle_disp(); cdb_valid = 1; cdb_rob = 4'd6;
        stuck = 0;
        repeat (4) begin
            @(negedge clk);
            if (issue_valid !== 1'b0) stuck = 1;
            cyc();
        end
        compared++;
        if (stuck !== 1'b0) begin
            mismatched++;
            $display("FAIL dep_nomatch: got early issue=%b, required 0", stuck);
        end
        cdb_rob = 4'd7;
        cyc(); cdb_valid = 0;
        @(negedge clk);
        compared++;
        if (issue_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL dep_wait_reg: got iv=%b, required 0", issue_valid);
        end
        cyc(); @(negedge clk);
        compared++;
        if (issue_valid !== 1'b1 || issue_rob !== 4'd5) begin
            mismatched++;
            $display("FAIL dep_ready: got iv=%b rob=%0d, required iv=1 rob=5", issue_valid, issue_rob);
        end
        cyc(); drain(); @(negedge clk);
        compared++;
        if (empty !== 1'b1 || sb.size() != 0) begin
            mismatched++;
            $display("FAIL dep_drain: got empty=%b pending=%0d, required 1 0", empty, sb.size());
        end
        cyc();
    endtask

    task automatic test_fill_order();
        valid_reg = '0;
        for (int r = 1; r <= 4; r++) begin
            drive_disp(PW'(19 + r), PW'(16 + r), RW'(r), 1'b0, 4'd0, 32'(r * 4));
            sb.push_back({RW'(r), PW'(16 + r), PW'(19 + r), 32'(r * 4)});
            cyc();
        end
        idle_disp();
        @(negedge clk);
        compared++;
        if ({full, disp_ready, occupancy, issue_valid} !== {1'b1, 1'b0, 3'd4, 1'b0}) begin
            mismatched++;
            $display("FAIL fill_full: got full=%b rdy=%b occ=%0d iv=%b, required 1 0 4 0",
                     full, disp_ready, occupancy, issue_valid);
        end
        cyc();
        drive_disp(6'd40, 6'd40, 4'd15, 1'b0, 4'd0, 32'hF);
        cyc(); idle_disp();
        @(negedge clk);
        compared++;
        if (occupancy !== 3'd4) begin
            mismatched++;
            $display("FAIL fill_refuse: got occ=%0d, required 4", occupancy);
        end
        cyc();
        valid_reg[23:20] = 4'hF;
        drain(); @(negedge clk);
        compared++;
        if (empty !== 1'b1 || sb.size() != 0) begin
            mismatched++;
            $display("FAIL fill_drain: got empty=%b pending=%0d, required 1 0", empty, sb.size());
        end
        cyc();
    endtask

    task automatic test_full_reuse();
        valid_reg = '0;
        for (int r = 1; r <= 4; r++) begin
            drive_disp(PW'(29 + r), PW'(r), RW'(r), 1'b0, 4'd0, 32'(r));
            cyc();
        end
        idle_disp();
        valid_reg[31] = 1;
        sb.push_back({4'd2, 6'd2, 6'd31, 32'd2});
        cyc(); @(negedge clk);
        compared++;
        if ({issue_valid, issue_rob, full} !== {1'b1, 4'd2, 1'b1}) begin
            mismatched++;
            $display("FAIL reuse_one_ready: got iv=%b rob=%0d full=%b, required 1 2 1", issue_valid, issue_rob, full);
        end
        cyc();
        drive_disp(6'd34, 6'd40, 4'd9, 1'b0, 4'd0, 32'h9);
        issue_ready = 1;
        @(negedge clk);
        compared++;
        if (disp_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL reuse_refused: got disp_ready=%b, required 0", disp_ready);
        end
        cyc(); issue_ready = 0;
        @(negedge clk);
        compared++;
        if (disp_ready !== 1'b1 || occupancy !== 3'd3) begin
            mismatched++;
            $display("FAIL reuse_freed: got rdy=%b occ=%0d, required 1 3", disp_ready, occupancy);
        end
        cyc(); idle_disp();
        @(negedge clk);
        compared++;
        if (occupancy !== 3'd4 || full !== 1'b1) begin
            mismatched++;
            $display("FAIL reuse_refill: got occ=%0d full=%b, required 4 1", occupancy, full);
        end
        cyc();
        valid_reg[30] = 1; valid_reg[32] = 1; valid_reg[33] = 1; valid_reg[34] = 1;
        // slot 1 now holds the youngest load, so index order is not age order
        sb.push_back({4'd1, 6'd1, 6'd30, 32'd1});
        sb.push_back({4'd3, 6'd3, 6'd32, 32'd3});
        sb.push_back({4'd4, 6'd4, 6'd33, 32'd4});
        sb.push_back({4'd9, 6'd40, 6'd34, 32'h9});
        drain(); @(negedge clk);
        compared++;
        if (empty !== 1'b1 || sb.size() != 0) begin
            mismatched++;
            $display("FAIL reuse_drain: got empty=%b pending=%0d, required 1 0", empty, sb.size());
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        valid_reg = '0; valid_reg[5] = 1;
        drive_disp(6'd5, 6'd2, 4'd1, 1'b0, 4'd0, 32'hA);
        sb.push_back({4'd1, 6'd2, 6'd5, 32'hA});
        cyc();
        drive_disp(6'd5, 6'd3, 4'd2, 1'b1, 4'd12, 32'hB);
        sb.push_back({4'd2, 6'd3, 6'd5, 32'hB});
        cyc(); idle_disp();
        @(negedge clk);
        compared++;
        if (issue_valid !== 1'b1 || issue_rob !== 4'd1) begin
            mismatched++;
            $display("FAIL b2b_first: got iv=%b rob=%0d, required 1 1", issue_valid, issue_rob);
        end
        cyc();
        drive_disp(6'd5, 6'd4, 4'd3, 1'b0, 4'd0, 32'hC);
        sb.push_back({4'd3, 6'd4, 6'd5, 32'hC});
        cdb_valid = 1; cdb_rob = 4'd12; issue_ready = 1;
        cyc(); idle_disp(); cdb_valid = 0; issue_ready = 0;
        @(negedge clk);
        compared++;
        if (occupancy !== 3'd2 || issue_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_parallel: got occ=%0d iv=%b, required 2 0", occupancy, issue_valid);
        end
        cyc(); @(negedge clk);
        compared++;
        if (issue_valid !== 1'b1 || issue_rob !== 4'd2) begin
            mismatched++;
            $display("FAIL b2b_age: got iv=%b rob=%0d, required 1 2", issue_valid, issue_rob);
        end
        cyc(); drain(); @(negedge clk);
        compared++;
        if (empty !== 1'b1 || sb.size() != 0) begin
            mismatched++;
            $display("FAIL b2b_drain: got empty=%b pending=%0d, required 1 0", empty, sb.size());
        end
        cyc();
    endtask

    task automatic test_flush();
        valid_reg = '0; valid_reg[5] = 1;
        for (int r = 1; r <= 3; r++) begin
            drive_disp(6'd5, PW'(r), RW'(r), 1'b0, 4'd0, 32'(r));
            cyc();
        end
        drive_disp(6'd5, 6'd8, 4'd8, 1'b0, 4'd0, 32'h8);
        issue_ready = 1; flush = 1;
        @(negedge clk);
        compared++;
        if (issue_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_masks_issue: got iv=%b, required 0", issue_valid);
        end
        cyc(); flush = 0; idle_disp(); issue_ready = 0;
        @(negedge clk);
        compared++;
        if ({occupancy, empty, issue_valid} !== {3'd0, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL flush_clear: got occ=%0d empty=%b iv=%b, required 0 1 0", occupancy, empty, issue_valid);
        end
        cyc(); cyc(); @(negedge clk);
        compared++;
        if (occupancy !== 3'd0 || issue_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_no_alloc: got occ=%0d iv=%b, required 0 0", occupancy, issue_valid);
        end
        cyc();
    endtask

    task automatic test_async_reset();
        valid_reg = '0; valid_reg[5] = 1;
        drive_disp(6'd5, 6'd1, 4'd1, 1'b0, 4'd0, 32'h1);
        cyc();
        drive_disp(6'd5, 6'd2, 4'd2, 1'b0, 4'd0, 32'h2);
        cyc(); idle_disp(); cyc();
        @(negedge clk);
        compared++;
        if (issue_valid !== 1'b1 || occupancy !== 3'd2) begin
            mismatched++;
            $display("FAIL areset_setup: got iv=%b occ=%0d, required 1 2", issue_valid, occupancy);
        end
        #2 rst = 0;
        #1;
        compared++;
        if ({issue_valid, empty, disp_ready, occupancy} !== {1'b0, 1'b1, 1'b1, 3'd0}) begin
            mismatched++;
            $display("FAIL areset_immediate: got iv=%b empty=%b rdy=%b occ=%0d, required 0 1 1 0",
                     issue_valid, empty, disp_ready, occupancy);
        end
        @(posedge clk); @(negedge clk);
        rst = 1;
        cyc(); issue_ready = 1;
        repeat (3) cyc();
        issue_ready = 0;
        @(negedge clk);
        compared++;
        if (occupancy !== 3'd0 || issue_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL areset_discard: got occ=%0d iv=%b, required 0 0", occupancy, issue_valid);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dep_bypass();
        test_store_dep();
        test_fill_order();
        test_full_reuse();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
